hc85_serial_cmp: RTL



---
 rtl/hc85_serial_cmp.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hc85_serial_cmp.sv
// hc85_serial_cmp
// ---------------
// Nibble-serial magnitude comparator. Behaves like a chain of NIBBLES
// cascaded HC85 4-bit comparators, but evaluates one 4-bit slice per clock,
// LSB slice first, through a registered cascade state (g, s, e).
//
// Parameters:
//   NIBBLES  number of 4-bit slices (2..16); operand width is 4*NIBBLES.
//
// Ports:
//   CLK                 system clock, rising edge.
//   RST                 asynchronous active-high reset; aborts any compare.
//   START               compare request, sampled only when BUSY=0.
//   A, B                operands, captured on the accepting edge.
//   IAGB, IASB, IAEB    cascade inputs for the LSB slice, captured with START.
//   BUSY                high while slices are being processed.
//   DONE                one-cycle pulse; QAGB/QASB/QAEB are valid from it on.
//   QAGB, QASB, QAEB    result A>B / A<B / A=B, held until the next DONE.

module hc85_serial_cmp #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   IAGB,
    input  logic                   IASB,
    input  logic                   IAEB,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   QAGB,
    output logic                   QASB,
    output logic                   QAEB
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned CntW = $clog2(NIBBLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

    if (NIBBLES < 2 || NIBBLES > 16) begin : g_bad_nibbles
        $error("hc85_serial_cmp: NIBBLES must be in 2..16");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    // One HC85 stage. Cascade vector is {g, s, e}. When the slices are equal
    // and e=0 the cascade passes through swapped and inverted, which is how
    // the real part treats its illegal input combinations (000 -> 110,
    // 110 -> 000); a chain of equal slices therefore toggles between them.
    function automatic logic [2:0] slice_step(input logic [3:0] na,
                                              input logic [3:0] nb,
                                              input logic [2:0] cas);
        logic [2:0] res;
        if (na > nb) begin
            res = 3'b100;
        end else if (na < nb) begin
            res = 3'b010;
        end else if (cas[0]) begin
            res = 3'b001;
        end else begin
            res = {~cas[1], ~cas[2], 1'b0};
        end
        return res;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic [2:0]      cas_q,   cas_d;
    logic [2:0]      res_q,   res_d;
    logic [2:0]      step;

    // Operands are shifted right each step, so the current slice is always
    // in bits 3:0.
    assign step = slice_step(a_q[3:0], b_q[3:0], cas_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cas_d   = cas_q;
        res_d   = res_q;

        unique case (state_q)
            // FIN accepts START exactly like IDLE, giving back-to-back operation.
            StIdle, StFin: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    cas_d   = {IAGB, IASB, IAEB};
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                cas_d = step;
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    res_d   = step;
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cas_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cas_q   <= cas_d;
            res_q   <= res_d;
        end
    end

    assign BUSY = (state_q == StRun);
    assign DONE = (state_q == StFin);
    assign QAGB = res_q[2];
    assign QASB = res_q[1];
    assign QAEB = res_q[0];

endmodule
